// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the architectural PC, issues one instruction-memory
// request at a time and presents fetched words to the IF/ID register.
// Execute-stage redirects take priority over stalls and acks. A request that
// is in flight when a redirect arrives is drained and its data discarded.
//
// state | meaning
// IDLE  | no request; waiting for the skid buffer to empty
// FETCH | request at pc outstanding
// DROP  | wrong-path request outstanding at drop_addr; its data is discarded
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        flush,
  output logic        misalign
);

  typedef enum logic [1:0] {IDLE, FETCH, DROP} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] drop_addr;
  logic        skid_v;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;

  logic consume;
  logic slot_free;
  logic ack_fetch;

  assign consume   = if_valid && !stall;
  assign slot_free = !if_valid || !stall;
  assign ack_fetch = (state == FETCH) && imem_ack;

  assign imem_req  = (state != IDLE);
  assign imem_addr = (state == DROP) ? drop_addr : pc;
  assign flush     = br_taken;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state; a redirect overrides the normal sequencing.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!skid_v || consume) state_nxt = FETCH;
      FETCH:   if (imem_ack) state_nxt = slot_free ? FETCH : IDLE;
      DROP:    if (imem_ack) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
    if (br_taken) begin
      state_nxt = (imem_req && !imem_ack) ? DROP : FETCH;
    end
  end

  // PC, output register, skid buffer and misalign pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      drop_addr  <= '0;
      if_valid   <= 1'b0;
      if_instr   <= NOP_INSTR;
      if_pc      <= '0;
      skid_v     <= 1'b0;
      skid_instr <= NOP_INSTR;
      skid_pc    <= '0;
      misalign   <= 1'b0;
    end else if (br_taken) begin
      pc       <= {br_target[31:2], 2'b00};
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
      skid_v   <= 1'b0;
      misalign <= |br_target[1:0];
      // Remember the in-flight address so it stays on the bus until acked;
      // a redirect already in DROP keeps the original drain address.
      if (state == FETCH && !imem_ack) begin
        drop_addr <= pc;
      end
    end else begin
      misalign <= 1'b0;
      if (ack_fetch) begin
        pc <= pc + 32'd4;
      end
      if (consume && skid_v) begin
        if_instr <= skid_instr;
        if_pc    <= skid_pc;
        skid_v   <= 1'b0;
      end else if (ack_fetch && slot_free) begin
        if_valid <= 1'b1;
        if_instr <= imem_rdata;
        if_pc    <= pc;
      end else if (consume) begin
        if_valid <= 1'b0;
        if_instr <= NOP_INSTR;
      end
      // Output is held by stall: park the word until the consumer frees up.
      if (ack_fetch && !slot_free) begin
        skid_v     <= 1'b1;
        skid_instr <= imem_rdata;
        skid_pc    <= pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed walk through the main scenarios followed by
// randomized stall/redirect/reset/latency traffic, scored against a program
// order model (next consumed PC, memory contents, misalign pulse).
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        br_taken;
  logic [31:0] br_target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        flush;
  logic        misalign;

  fetch_ctrl #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .flush      (flush),
    .misalign   (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  int          lat = 0;
  bit          busy = 0;
  int          cnt = 0;
  logic [31:0] hold_addr = '0;
  logic [31:0] exp_pc = RESET_PC;
  logic        exp_mis = 1'b0;
  int          no_prog = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5A13;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, answer the memory port, score outputs.
  task automatic run_cycle(input logic r, input logic s, input logic b, input logic [31:0] t);
    logic cons;
    @(posedge clk);
    #1;
    rst_n     = r;
    stall     = s;
    br_taken  = b;
    br_target = t;
    if (!r) begin
      busy       = 0;
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
    end else begin
      if (busy) begin
        check("req_held", 32'(imem_req), 32'd1);
        check("addr_stable", imem_addr, hold_addr);
      end
      if (imem_req) begin
        if (!busy) begin
          busy      = 1;
          hold_addr = imem_addr;
          cnt       = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
        end
        imem_ack   = (cnt == 0);
        imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom;
        if (cnt == 0) busy = 0;
        else cnt--;
      end else begin
        busy       = 0;
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
      end
    end
    #1;
    check("flush", 32'(flush), 32'(b));
    if (r) begin
      check("misalign", 32'(misalign), 32'(exp_mis));
      if (!if_valid) check("nop_when_empty", if_instr, NOP_INSTR);
      cons = !b && !s && if_valid;
      if (cons) begin
        check("order_pc", if_pc, exp_pc);
        check("order_instr", if_instr, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
      end
      if (cons || b) no_prog = 0;
      else if (!s) no_prog++;
      check("progress", 32'(no_prog > 16), 32'd0);
      if (no_prog > 16) no_prog = 0;
    end else begin
      no_prog = 0;
    end
    if (!r) exp_pc = RESET_PC;
    else if (b) exp_pc = {t[31:2], 2'b00};
    exp_mis = r && b && (t[1:0] != 2'b00);
  endtask

  logic        rr, rs, rb;
  logic [31:0] rt;

  initial begin
    rst_n = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = '0;
    imem_ack = 1'b0; imem_rdata = '0;

    // reset
    lat = 0;
    run_cycle(0, 0, 0, 0);
    run_cycle(0, 0, 0, 0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_instr", if_instr, NOP_INSTR);
    check("rst_pc", if_pc, 32'h0);
    check("rst_misalign", 32'(misalign), 32'd0);

    // free run, zero-wait ack
    run_cycle(1, 0, 0, 0);
    check("idle_req", 32'(imem_req), 32'd0);
    run_cycle(1, 0, 0, 0);
    check("run_addr0", imem_addr, 32'h0);
    check("run_req", 32'(imem_req), 32'd1);
    run_cycle(1, 0, 0, 0);
    check("run_addr4", imem_addr, 32'h4);
    check("run_ifpc0", if_pc, 32'h0);
    check("run_valid", 32'(if_valid), 32'd1);
    run_cycle(1, 0, 0, 0);
    check("run_addr8", imem_addr, 32'h8);
    check("run_ifpc4", if_pc, 32'h4);

    // stall 3 cycles with if_pc=0x8
    run_cycle(1, 1, 0, 0);
    check("stall_ifpc8", if_pc, 32'h8);
    check("stall_addrc", imem_addr, 32'hC);
    run_cycle(1, 1, 0, 0);
    check("stall_req_drop", 32'(imem_req), 32'd0);
    check("stall_hold1", if_pc, 32'h8);
    run_cycle(1, 1, 0, 0);
    check("stall_hold2", if_pc, 32'h8);
    check("stall_valid", 32'(if_valid), 32'd1);
    run_cycle(1, 0, 0, 0);
    run_cycle(1, 0, 0, 0);
    check("skid_out", if_pc, 32'hC);
    check("resume_addr", imem_addr, 32'h10);
    check("resume_req", 32'(imem_req), 32'd1);

    // redirect during a 3-wait fetch
    lat = 3;
    run_cycle(1, 0, 0, 0);
    check("wait_addr", imem_addr, 32'h14);
    run_cycle(1, 0, 1, 32'h100);
    check("drop_flush", 32'(flush), 32'd1);
    run_cycle(1, 0, 0, 0);
    check("drop_addr_hold", imem_addr, 32'h14);
    check("drop_valid", 32'(if_valid), 32'd0);
    run_cycle(1, 0, 0, 0);
    check("drop_ack_addr", imem_addr, 32'h14);
    lat = 0;
    run_cycle(1, 0, 0, 0);
    check("redir_addr", imem_addr, 32'h100);

    // redirect coinciding with ack under stall
    run_cycle(1, 1, 1, 32'h200);
    check("ackbr_ifpc", if_pc, 32'h100);
    check("ackbr_flush", 32'(flush), 32'd1);
    // misaligned redirect, issued together with the zero-wait ack at 0x200
    run_cycle(1, 0, 1, 32'h203);
    check("ackbr_valid", 32'(if_valid), 32'd0);
    check("ackbr_instr", if_instr, NOP_INSTR);
    check("ackbr_addr", imem_addr, 32'h200);
    lat = 3;
    run_cycle(1, 0, 0, 0);
    check("mis_pulse", 32'(misalign), 32'd1);
    check("mis_addr", imem_addr, 32'h200);
    run_cycle(1, 0, 0, 0);
    check("mis_clear", 32'(misalign), 32'd0);

    // reset with a request outstanding
    run_cycle(0, 0, 0, 0);
    check("rst_mid_req", 32'(imem_req), 32'd1);
    run_cycle(1, 0, 0, 0);
    check("rst_mid_drop", 32'(imem_req), 32'd0);
    lat = 0;
    run_cycle(1, 0, 0, 0);
    check("rst_restart", imem_addr, RESET_PC);

    // pc wrap
    run_cycle(1, 0, 1, 32'hFFFF_FFFC);
    run_cycle(1, 0, 0, 0);
    check("wrap_top", imem_addr, 32'hFFFF_FFFC);
    run_cycle(1, 0, 0, 0);
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_ifpc", if_pc, 32'hFFFF_FFFC);

    // randomized traffic
    lat = -1;
    for (int i = 0; i < 3000; i++) begin
      rr = ($urandom_range(0, 199) != 0);
      rs = ($urandom_range(0, 2) == 0);
      rb = ($urandom_range(0, 11) == 0);
      rt = $urandom;
      if ($urandom_range(0, 1) == 0) rt[1:0] = 2'b00;
      run_cycle(rr, rs, rb, rt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
